// File: rtl/leaf_uart_pkg.sv
// Shared UART types and constants for the leaf console RX/TX paths.
package leaf_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/leaf_uart_fifo.sv
// Show-ahead synchronous FIFO; head is read combinationally from storage.
module leaf_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_uart_rx.sv
// 8N1 UART receiver: synchronizer, bit timer, shift register and FSM feeding
// a small show-ahead FIFO with a valid/ready consumer interface.
module leaf_uart_rx
    import leaf_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic                      rx_meta, rxs, rxs_prev;
    logic [TW-1:0]             timer_q, reload_val;
    logic [BW-1:0]             bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      tick, reload, shift_en;
    logic                      push, pop, ferr_set, ovr_set;
    logic                      fifo_full, fifo_empty;

    assign tick     = (timer_q == '0);
    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;

    // Synchronizer and edge-detect history idle high so reset never fakes a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rxs_prev && !rxs)                 state_d = START;
            START:   if (tick)                             state_d = rxs ? IDLE : DATA;
            DATA:    if (tick && bit_idx_q == LAST_BIT)    state_d = STOP;
            STOP:    if (tick)                             state_d = rxs ? IDLE : BREAK;
            BREAK:   if (rxs)                              state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        shift_en   = (state_q == DATA) && tick;
        reload     = (state_d != state_q) || shift_en;
        reload_val = (state_d == START) ? HALF_LOAD : FULL_LOAD;
        if (state_q == STOP && tick) begin
            push     = rxs && (!fifo_full || pop);
            ovr_set  = rxs && fifo_full && !pop;
            ferr_set = !rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (reload)     timer_q <= reload_val;
            else if (!tick) timer_q <= timer_q - 1'b1;

            if (state_d == DATA && state_q != DATA) bit_idx_q <= '0;
            else if (shift_en)                      bit_idx_q <= bit_idx_q + 1'b1;

            if (shift_en) shift_q <= {rxs, shift_q[UART_DATA_BITS-1:1]};

            frame_err <= ferr_set;
            overrun   <= ovr_set;
        end
    end

    leaf_uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_leaf_uart_rx.sv
// Bench for leaf_uart_rx: table-driven frames, hand-written corner sequences
// and random bytes checked against a queue-based reference.
module tb_leaf_uart_rx;

    localparam int CPB = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;

    int      checks = 0;
    int      errors = 0;
    logic    ready_lvl = 1'b0;
    logic    rnd_mode = 1'b0;
    byte_q_t got_q;
    int      ferr_cnt = 0;
    int      ovr_cnt = 0;

    leaf_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Consumer: rx_ready moves 2ns after each rising edge so it is stable well before sampling.
    always @(posedge clk) begin
        #2;
        rx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_lvl;
    end

    // Observed handshakes and error pulses (a pop happens at the next rising edge).
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bytes(input string name, input int base, input byte_q_t exp);
        logic [31:0] act;
        check({name, " count"}, 32'(got_q.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            act = (base + i < got_q.size()) ? 32'(got_q[base + i]) : 32'hDEAD;
            check($sformatf("%s byte%0d", name, i), act, 32'(exp[i]));
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
    endtask

    task automatic check_outputs_zero(input string name);
        @(negedge clk);
        check({name, " rx_valid"},  32'(rx_valid),  32'd0);
        check({name, " rx_data"},   32'(rx_data),   32'd0);
        check({name, " frame_err"}, 32'(frame_err), 32'd0);
        check({name, " overrun"},   32'(overrun),   32'd0);
    endtask

    initial begin
        vec_t    vecs[7];
        int      gb, fb, ob;
        byte_q_t exp;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        tick();
        reset = 1'b0;
        ready_lvl = 1'b1;
        idle(4);

        // Table-driven single frames, consumer always ready
        for (int v = 0; v < 7; v++) begin
            gb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit);
            rx = 1'b1;
            idle(2 * CPB);
            exp.delete();
            if (vecs[v].exp_push) exp.push_back(vecs[v].data);
            check_bytes($sformatf("vec%0d", v), gb, exp);
            check($sformatf("vec%0d frame_err", v), 32'(ferr_cnt - fb), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d overrun", v), 32'(ovr_cnt - ob), 32'd0);
        end

        // Back-to-back with consumer stalled: fifth byte overruns
        ready_lvl = 1'b0;
        idle(2);
        gb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        rx = 1'b1;
        idle(2 * CPB);
        check("stall overrun", 32'(ovr_cnt - ob), 32'd1);
        check("stall frame_err", 32'(ferr_cnt - fb), 32'd0);
        check("stall no pop", 32'(got_q.size() - gb), 32'd0);
        check("stall valid", 32'(rx_valid), 32'd1);
        check("stall head", 32'(rx_data), 32'h00);
        ready_lvl = 1'b1;
        idle(10);
        check_bytes("stall drain", gb, '{8'h00, 8'hFF, 8'h3C, 8'h81});
        check("stall drained valid", 32'(rx_valid), 32'd0);

        // Glitch: short low pulse is a false start
        gb = got_q.size(); fb = ferr_cnt;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(3 * CPB);
        check("glitch push", 32'(got_q.size() - gb), 32'd0);
        check("glitch frame_err", 32'(ferr_cnt - fb), 32'd0);

        // Framing error followed by a long break, then a good frame
        gb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        send_frame(8'h55, 1'b0);
        idle(40 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        check("break frame_err", 32'(ferr_cnt - fb), 32'd1);
        check("break push", 32'(got_q.size() - gb), 32'd0);
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        idle(2 * CPB);
        check_bytes("after break", gb, '{8'h12});
        check("break overrun", 32'(ovr_cnt - ob), 32'd0);

        // Reset mid-frame: a buffered byte and the partial frame are both lost
        ready_lvl = 1'b0;
        send_frame(8'h44, 1'b1);
        rx = 1'b1;
        idle(2 * CPB);
        check("pre-reset valid", 32'(rx_valid), 32'd1);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'hC3 >> i);
            idle(CPB);
        end
        rx = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        check_outputs_zero("in reset");
        idle(3);
        reset = 1'b0;
        idle(2 * CPB);
        check("post-reset valid", 32'(rx_valid), 32'd0);
        gb = got_q.size();
        ready_lvl = 1'b1;
        send_frame(8'h99, 1'b1);
        rx = 1'b1;
        idle(2 * CPB);
        check_bytes("post-reset", gb, '{8'h99});

        // Push and pop on the same edge while full
        ready_lvl = 1'b0;
        idle(2);
        gb = got_q.size(); ob = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                // stop sample: 3 cycles detect + CPB/2 + 9*CPB after the falling edge
                idle(3 + CPB / 2 + 9 * CPB - 1);
                ready_lvl = 1'b1;
                tick();
                ready_lvl = 1'b0;
            end
        join
        rx = 1'b1;
        idle(2 * CPB);
        check("pushpop overrun", 32'(ovr_cnt - ob), 32'd0);
        check_bytes("pushpop popped", gb, '{8'h11});
        ready_lvl = 1'b1;
        idle(10);
        check_bytes("pushpop drain", gb, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

        // Random bytes, random gaps, random consumer; reference is an in-order queue
        gb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        exp.delete();
        rnd_mode = 1'b1;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            exp.push_back(d);
            send_frame(d, 1'b1);
            rx = 1'b1;
            idle($urandom_range(0, 3 * CPB));
        end
        idle(3 * CPB);
        rnd_mode = 1'b0;
        ready_lvl = 1'b1;
        idle(20);
        check_bytes("random", gb, exp);
        check("random frame_err", 32'(ferr_cnt - fb), 32'd0);
        check("random overrun", 32'(ovr_cnt - ob), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
